// File: rtl/instr_encoder_loader.sv
// Field-bundle to RV32I encoder that streams words into instruction memory.
// Optional immediate range checking is enabled by defining ENC_IMM_CHECK_EN.
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        op_class,
    input  logic [2:0]        alu_op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err,
    output logic              ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP  = '1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    logic [2:0]  f3_alu;
    logic        alu_bad;
    logic [6:0]  f7;
    logic [31:0] enc;
    logic        bad;
    logic        imm_i_ok, imm_b_ok, imm_j_ok;
    logic        xfer;

    always_comb begin
        f3_alu  = 3'b000;
        alu_bad = 1'b0;
        unique case (alu_op)
            3'b000:  f3_alu = 3'b000;
            3'b001:  f3_alu = 3'b000;
            3'b010:  f3_alu = 3'b111;
            3'b011:  f3_alu = 3'b110;
            3'b101:  f3_alu = 3'b010;
            default: alu_bad = 1'b1;
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    assign imm_i_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign imm_b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign imm_j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
`else
    logic unused_imm;
    assign unused_imm = ^imm[31:21];
    assign imm_i_ok   = 1'b1;
    assign imm_b_ok   = 1'b1;
    assign imm_j_ok   = 1'b1;
`endif

    assign f7 = (alu_op == 3'b001) ? 7'b0100000 : 7'b0000000;

    always_comb begin
        enc = '0;
        bad = 1'b0;
        unique case (op_class)
            3'd0: begin
                enc = {f7, rs2, rs1, f3_alu, rd, OP_R};
                bad = alu_bad;
            end
            3'd1: begin
                enc = {imm[11:0], rs1, f3_alu, rd, OP_I};
                bad = alu_bad | (alu_op == 3'b001) | ~imm_i_ok;
            end
            3'd2: begin
                enc = {imm[11:0], rs1, 3'b010, rd, OP_LW};
                bad = ~imm_i_ok;
            end
            3'd3: begin
                enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
                bad = ~imm_i_ok;
            end
            3'd4: begin
                enc = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                       imm[4:1], imm[11], OP_BEQ};
                bad = ~imm_b_ok;
            end
            3'd5: begin
                enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                bad = ~imm_j_ok;
            end
            default: bad = 1'b1;
        endcase
    end

    assign in_ready = (state_q == S_LOAD);
    assign xfer     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = BASE;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    if (bad) begin
                        err_d = 1'b1;
                        if (in_last) state_d = S_DONE;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc;
                        ptr_d   = ptr_q + 1'b1;
                        // top address written: no room left in this session
                        if (ptr_q == TOP) begin
                            ovf_d   = 1'b1;
                            state_d = S_DONE;
                        end else if (in_last) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE;
            addr_q  <= BASE;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign ovf        = ovf_q;
    assign done       = (state_q == S_DONE);

endmodule
